// File: rtl/dat_fill_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// dat_fill_sequencer_pkg
// Shared definitions for the DAT fill sequencer:
//   - fill engine state encoding
//   - fill mode constants
//   - default DAT word address width
//   - helper that forms the word written by the fill engine
// ----------------------------------------------------------------------------
package dat_fill_sequencer_pkg;

   // Default DAT word address width (32K task-register words).
   localparam int DAT_AW = 15;

   // Fill modes, latched at start.
   localparam logic FILL_IDENTITY = 1'b0;
   localparam logic FILL_CONST    = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_NEXT  = 2'd3
   } fill_state_e;

   // Identity fill maps each word onto its own 8K slot (board pass-through);
   // constant fill writes the latched word everywhere.
   function automatic logic [15:0] fill_word(input logic        mode,
                                             input logic [15:0] const_data,
                                             input logic [7:0]  slot);
      return (mode == FILL_CONST) ? const_data : {8'h00, slot};
   endfunction

endpackage

// File: rtl/dat_port_mux.sv
// ----------------------------------------------------------------------------
// dat_port_mux
// Combinational select of the DAT SRAM port between the CPU decode and the
// fill engine. The CPU wins whenever sel_cpu_i is high.
// Ports:
//   sel_cpu_i          1   route CPU signals to the SRAM pins
//   cpu_addr_i         AW  CPU address
//   cpu_wdata_i        16  CPU write data
//   cpu_we_l_i/_h_i    1   CPU byte strobes
//   eng_addr_i         AW  fill engine address
//   eng_wdata_i        16  fill engine data
//   eng_we_i           1   fill engine strobe (both bytes)
//   dat_addr_o         AW  SRAM address
//   dat_wdata_o        16  SRAM write data
//   dat_we_l_o/_h_o    1   SRAM byte write enables, active high
// ----------------------------------------------------------------------------
module dat_port_mux
   import dat_fill_sequencer_pkg::*;
#(
   parameter int AW = DAT_AW
) (
   input  logic          sel_cpu_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [15:0]   cpu_wdata_i,
   input  logic          cpu_we_l_i,
   input  logic          cpu_we_h_i,
   input  logic [AW-1:0] eng_addr_i,
   input  logic [15:0]   eng_wdata_i,
   input  logic          eng_we_i,
   output logic [AW-1:0] dat_addr_o,
   output logic [15:0]   dat_wdata_o,
   output logic          dat_we_l_o,
   output logic          dat_we_h_o
);

   always_comb begin
      // NOTE: every output gets a value on every path (defaults first), so no latch is inferred.
      dat_addr_o  = eng_addr_i;
      dat_wdata_o = eng_wdata_i;
      dat_we_l_o  = eng_we_i;
      dat_we_h_o  = eng_we_i;
      if (sel_cpu_i) begin
         dat_addr_o  = cpu_addr_i;
         dat_wdata_o = cpu_wdata_i;
         dat_we_l_o  = cpu_we_l_i;
         dat_we_h_o  = cpu_we_h_i;
      end
   end

endmodule

// File: rtl/dat_fill_sequencer.sv
// ----------------------------------------------------------------------------
// dat_fill_sequencer
// Arbiter and sequencer for the DAT task-register SRAM. The CPU has absolute
// priority on the port; otherwise a fill engine walks every word writing an
// identity map or a constant, three cycles per word (SETUP, WRITE, NEXT).
// Ports:
//   e            1   clock, rising edge
//   _reset       1   synchronous active-low reset
//   start        1   fill request, sampled in IDLE
//   abort        1   stop the fill at the next word boundary, no done
//   mode         1   0 identity / 1 constant, latched at start
//   fill_data    16  constant fill word, latched at start
//   cpu_req      1   CPU owns the DAT port this cycle
//   cpu_addr     AW  CPU address
//   cpu_wdata    16  CPU write data
//   cpu_we_l/_h  1   CPU byte strobes
//   dat_addr     AW  SRAM address
//   dat_wdata    16  SRAM write data
//   dat_we_l/_h  1   SRAM byte write enables, active high
//   busy         1   fill in progress
//   done         1   one-cycle pulse after the last word
// ----------------------------------------------------------------------------
module dat_fill_sequencer
   import dat_fill_sequencer_pkg::*;
#(
   parameter int AW        = DAT_AW,
   parameter int SLOT_BITS = 3
) (
   input  logic          e,
   input  logic          _reset,
   input  logic          start,
   input  logic          abort,
   input  logic          mode,
   input  logic [15:0]   fill_data,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   input  logic [15:0]   cpu_wdata,
   input  logic          cpu_we_l,
   input  logic          cpu_we_h,
   output logic [AW-1:0] dat_addr,
   output logic [15:0]   dat_wdata,
   output logic          dat_we_l,
   output logic          dat_we_h,
   output logic          busy,
   output logic          done
);

   fill_state_e   state_q;
   logic [AW-1:0] counter_q;
   logic          mode_q;
   logic [15:0]   fill_data_q;
   logic          abort_q;
   logic          busy_q;
   logic          done_q;
   logic          eng_we_q;

   logic          abort_pend;
   logic [7:0]    slot;
   logic [15:0]   eng_wdata;

   // An abort seen in SETUP/WRITE (or while frozen) is remembered until NEXT.
   assign abort_pend = abort_q | abort;

   always_comb begin
      slot                 = 8'h00;
      slot[SLOT_BITS-1:0]  = counter_q[SLOT_BITS-1:0];
   end

   assign eng_wdata = fill_word(mode_q, fill_data_q, slot);

   // NOTE: state registers use non-blocking assignments so every update in this block sees pre-edge values.
   always_ff @(posedge e) begin
      if (!_reset) begin
         state_q     <= ST_IDLE;
         counter_q   <= '0;
         mode_q      <= FILL_IDENTITY;
         fill_data_q <= 16'h0000;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         eng_we_q    <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         eng_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // abort is meaningless here; a simultaneous start wins.
               if (start) begin
                  state_q     <= ST_SETUP;
                  counter_q   <= '0;
                  mode_q      <= mode;
                  fill_data_q <= fill_data;
                  abort_q     <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            ST_SETUP: begin
               abort_q <= abort_pend;
               if (!cpu_req) begin
                  state_q  <= ST_WRITE;
                  eng_we_q <= 1'b1;
               end
            end
            ST_WRITE: begin
               abort_q <= abort_pend;
               // A write stolen by the CPU is retried from SETUP so the address
               // is always set up a cycle before the strobe.
               state_q <= cpu_req ? ST_SETUP : ST_NEXT;
            end
            ST_NEXT: begin
               if (cpu_req) begin
                  abort_q <= abort_pend;
               end else if (abort_pend) begin
                  state_q   <= ST_IDLE;
                  counter_q <= '0;
                  abort_q   <= 1'b0;
                  busy_q    <= 1'b0;
               end else if (counter_q == {AW{1'b1}}) begin
                  state_q   <= ST_IDLE;
                  counter_q <= counter_q + AW'(1);
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end else begin
                  state_q   <= ST_SETUP;
                  counter_q <= counter_q + AW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   dat_port_mux #(.AW(AW)) u_mux (
      .sel_cpu_i   (cpu_req | ~busy_q),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_we_l_i  (cpu_we_l),
      .cpu_we_h_i  (cpu_we_h),
      .eng_addr_i  (counter_q),
      .eng_wdata_i (eng_wdata),
      .eng_we_i    (eng_we_q),
      .dat_addr_o  (dat_addr),
      .dat_wdata_o (dat_wdata),
      .dat_we_l_o  (dat_we_l),
      .dat_we_h_o  (dat_we_h)
   );

endmodule

// File: tb/tb_dat_fill_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dat_fill_sequencer
// Bench for dat_fill_sequencer with AW=4 (16 words). Expected engine writes,
// busy window and done cycle are computed from the fill timing rules: word n
// is written at start+2+3n, shifted by any CPU freeze that stalls it.
// ----------------------------------------------------------------------------
module tb_dat_fill_sequencer;

   localparam int AW = 4;

   logic          e = 1'b0;
   logic          rst_l;
   logic          start, abort, mode;
   logic [15:0]   fill_data;
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [15:0]   cpu_wdata;
   logic          cpu_we_l, cpu_we_h;
   logic [AW-1:0] dat_addr;
   logic [15:0]   dat_wdata;
   logic          dat_we_l, dat_we_h;
   logic          busy, done;

   always #5 e = ~e;

   dat_fill_sequencer #(.AW(AW), .SLOT_BITS(3)) dut (
      .e         (e),
      ._reset    (rst_l),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .fill_data (fill_data),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we_l  (cpu_we_l),
      .cpu_we_h  (cpu_we_h),
      .dat_addr  (dat_addr),
      .dat_wdata (dat_wdata),
      .dat_we_l  (dat_we_l),
      .dat_we_h  (dat_we_h),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      int t;
      int addr;
      int data;
   } wr_t;

   wr_t got_q[$];
   wr_t exp_q[$];

   int cyc_n     = 0;
   int n_chk     = 0;
   int n_fail    = 0;
   int busy_from = -100;
   int busy_to   = -100;
   int done_at   = -1;
   bit chk_en    = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
      end
   endtask

   // One clock cycle: inputs are already driven; sample mid-cycle, then advance.
   task automatic cyc();
      bit  exp_busy;
      wr_t w;
      #2;
      if (chk_en) begin
         exp_busy = (cyc_n >= busy_from) && (cyc_n <= busy_to);
         check("busy", busy, exp_busy);
         check("done", done, cyc_n == done_at);
         if (cpu_req || !exp_busy) begin
            check("pt_addr", dat_addr, cpu_addr);
            check("pt_wdata", dat_wdata, cpu_wdata);
            check("pt_we_l", dat_we_l, cpu_we_l);
            check("pt_we_h", dat_we_h, cpu_we_h);
         end else begin
            check("we_pair", dat_we_h, dat_we_l);
            if (dat_we_l || dat_we_h) begin
               w.t    = cyc_n;
               w.addr = dat_addr;
               w.data = dat_wdata;
               got_q.push_back(w);
            end
         end
      end
      @(posedge e);
      #1;
      cyc_n++;
   endtask

   // One fill run. fz_*: one CPU freeze of fz_len cycles starting at phase
   // fz_phase (0 SETUP, 1 WRITE, 2 NEXT) of word fz_word. ab_word: abort in
   // SETUP of that word. rst_word: reset in SETUP of that word. poke: extra
   // start pulses while busy. st_ab: abort together with the start pulse.
   task automatic do_fill(input bit m, input logic [15:0] fd,
                          input int fz_word, input int fz_phase, input int fz_len,
                          input int ab_word, input int rst_word,
                          input bit poke, input bit st_ab);
      int  s, delay, nw, fc, ac, rc, last, c, n_cmp;
      wr_t w;
      s     = cyc_n;
      delay = (fz_word >= 0) ? fz_len + ((fz_phase == 1) ? 1 : 0) : 0;
      nw    = 16;
      if (ab_word >= 0) nw = ab_word + 1;
      if (rst_word >= 0) nw = rst_word;
      got_q.delete();
      exp_q.delete();
      for (int n = 0; n < nw; n++) begin
         w.t = s + 2 + 3 * n;
         if (fz_word >= 0 && (n > fz_word || (n == fz_word && fz_phase != 2)))
            w.t += delay;
         w.addr = n;
         w.data = m ? int'(fd) : (n & 7);
         exp_q.push_back(w);
      end
      busy_from = s + 1;
      if (rst_word >= 0) begin
         busy_to = s + 1 + 3 * rst_word;
         done_at = -1;
      end else if (ab_word >= 0) begin
         busy_to = s + 3 * nw;
         done_at = -1;
      end else begin
         busy_to = s + 48 + delay;
         done_at = s + 49 + delay;
      end
      fc   = (fz_word >= 0) ? s + 1 + 3 * fz_word + fz_phase : -1;
      ac   = (ab_word >= 0) ? s + 1 + 3 * ab_word : -1;
      rc   = (rst_word >= 0) ? s + 1 + 3 * rst_word : -1;
      last = busy_to + 4;
      while (cyc_n <= last) begin
         c         = cyc_n;
         start     = (c == s) || (poke && (c == s + 7 || c == s + 20 || c == busy_to));
         abort     = (c == ac) || (st_ab && c == s);
         rst_l     = (c != rc);
         mode      = (c == s) ? m : 1'($urandom);
         fill_data = (c == s) ? fd : 16'($urandom);
         cpu_req   = (fc >= 0) && (c >= fc) && (c < fc + fz_len);
         cpu_addr  = AW'($urandom);
         cpu_wdata = 16'($urandom);
         if (cpu_req || c > busy_to) begin
            cpu_we_l = 1'($urandom);
            cpu_we_h = 1'($urandom);
         end else begin
            cpu_we_l = 1'b0;
            cpu_we_h = 1'b0;
         end
         cyc();
      end
      start    = 1'b0;
      abort    = 1'b0;
      rst_l    = 1'b1;
      cpu_req  = 1'b0;
      cpu_we_l = 1'b0;
      cpu_we_h = 1'b0;
      check("n_writes", got_q.size(), exp_q.size());
      n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n_cmp; i++) begin
         check("wr_cycle", got_q[i].t - s, exp_q[i].t - s);
         check("wr_addr", got_q[i].addr, exp_q[i].addr);
         check("wr_data", got_q[i].data, exp_q[i].data);
      end
   endtask

   initial begin
      rst_l     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      mode      = 1'b0;
      fill_data = 16'h0000;
      cpu_req   = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = 16'h0000;
      cpu_we_l  = 1'b0;
      cpu_we_h  = 1'b0;
      repeat (2) @(posedge e);
      #1;
      chk_en = 1'b1;

      // Reset state: idle, no done, port follows the CPU.
      cpu_addr  = 4'h9;
      cpu_wdata = 16'hBEEF;
      cpu_we_l  = 1'b1;
      cpu_we_h  = 1'b0;
      cyc();
      rst_l    = 1'b1;
      cpu_we_l = 1'b0;
      cyc();

      // Identity fill.
      do_fill(1'b0, 16'h0000, -1, 0, 0, -1, -1, 1'b0, 1'b0);
      // Constant fill, abort together with start is discarded.
      do_fill(1'b1, 16'hA55A, -1, 0, 0, -1, -1, 1'b0, 1'b1);
      // CPU steals the WRITE of word 5 for two cycles.
      do_fill(1'b0, 16'h0000, 5, 1, 2, -1, -1, 1'b0, 1'b0);
      // Abort in SETUP of word 3.
      do_fill(1'b0, 16'h0000, -1, 0, 0, 3, -1, 1'b0, 1'b0);
      // Next fill restarts at word 0; start pulses while busy are ignored.
      do_fill(1'b1, 16'h1234, -1, 0, 0, -1, -1, 1'b1, 1'b0);
      // Reset during word 7.
      do_fill(1'b1, 16'h5A5A, -1, 0, 0, -1, 7, 1'b0, 1'b0);
      // Freeze in NEXT of the last word delays done.
      do_fill(1'b1, 16'hFFFF, 15, 2, 3, -1, -1, 1'b0, 1'b0);

      // Randomized fills with an optional freeze.
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 3) == 0)
            do_fill(1'($urandom), 16'($urandom), -1, 0, 0, -1, -1, 1'b0, 1'b0);
         else
            do_fill(1'($urandom), 16'($urandom), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 3)),
                    -1, -1, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dat_fill_sequencer.md
Name: dat_fill_sequencer

Overview:
- Arbiter and sequencer for the DAT task-register SRAM (16-bit word, split low/high write enables).
- Shares the SRAM port between CPU DAT accesses and an internal fill engine.
- Fill engine walks every DAT word after a start command, writing either a pass-through identity map or a constant value, so software does not have to clear all tasks by hand.
- Sits between the MMU address/data decode and the DAT SRAM pins.

Parameters:
- AW, 15, DAT word address width; entries = 2^AW.
- SLOT_BITS, 3, low address bits holding the 8K slot index within a task.

Ports:
- e  input  1  system clock (CPU E); all state updates on rising edge.
- _reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle fill request; sampled only in IDLE.
- abort  input  1  stop fill at the next word boundary; no done pulse.
- mode  input  1  0 = identity fill, 1 = constant fill; latched at start.
- fill_data  input  16  constant fill word for mode 1; latched at start.
- cpu_req  input  1  CPU owns the DAT port this cycle.
- cpu_addr  input  AW  CPU DAT address.
- cpu_wdata  input  16  CPU write data.
- cpu_we_l  input  1  CPU low-byte write strobe, active high.
- cpu_we_h  input  1  CPU high-byte write strobe, active high.
- dat_addr  output  AW  SRAM address.
- dat_wdata  output  16  SRAM write data.
- dat_we_l  output  1  low-byte write enable, active high; board pin inverts it.
- dat_we_h  output  1  high-byte write enable, active high.
- busy  output  1  fill in progress.
- done  output  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (_reset low at an edge): state=IDLE, counter=0, busy=0, done=0, latched mode/data cleared. dat_* then follow cpu_* combinationally.
- Fill engine states:
  - IDLE: start=1 → SETUP with counter=0. start while busy is ignored.
  - SETUP: drive address and data, write enables low → WRITE.
  - WRITE: drive address and data, assert dat_we_l and dat_we_h for exactly one cycle → NEXT.
  - NEXT: write enables low. If counter = 2^AW-1 → IDLE, pulse done next cycle, counter wraps to 0. Otherwise counter+1 → SETUP.
- Fill data:
  - mode 0: low byte = {zeros, counter[SLOT_BITS-1:0]} (bank 0-7 = board pass-through); high byte = 0.
  - mode 1: the latched fill_data.
- Timing, uninterrupted fill (start accepted at cycle 0):
  - word n: SETUP at cycle 1+3n, WRITE at 2+3n, NEXT at 3+3n.
  - busy high in cycles 1 through 3·2^AW.
  - done high in cycle 3·2^AW+1 only.
- Arbitration:
  - cpu_req=1 gives the CPU absolute priority: dat_* = cpu_* combinationally in the same cycle.
  - The engine freezes: counter held, its write strobes suppressed.
  - If cpu_req is high in WRITE, that write does not happen. On cpu_req release the engine re-enters SETUP for the same counter value, so address setup precedes every engine write.
  - If cpu_req is high in SETUP or NEXT, the engine holds state. It resumes in that state when cpu_req drops; NEXT does not increment while frozen.
  - When cpu_req=0 and the engine is IDLE, dat_* = cpu_* (strobes are then 0 from the decode).
- abort:
  - Acts in NEXT: → IDLE, no done, counter reset to 0.
  - In SETUP or WRITE it is registered and honoured at the following NEXT, so a word in flight always completes.
  - Ignored in IDLE.
- start and abort in the same cycle while IDLE: start wins, abort discarded.
- Reset mid-fill: immediate IDLE; partial contents remain in SRAM; no done.
- Counter is AW bits and wraps naturally; no other arithmetic.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, SETUP=2'd1, WRITE=2'd2, NEXT=2'd3);
  - FILL_IDENTITY/FILL_CONST constants;
  - the default DAT_AW=15.
- One natural sub-module: dat_port_mux, the combinational CPU/engine select for address, data and strobes. The FSM and counter stay in the top level.

Test Plan:
- AW=4, reset, start mode 0 → 16 writes; word n at WRITE cycle 2+3n with data 16'h000(n&7); busy cycles 1-48; done only at cycle 49.
- Mode 1, fill_data=16'hA55A → all 16 words written A55A; fill_data changed mid-fill has no effect.
- Fill running, cpu_req high for 2 cycles during WRITE of word 5 → no engine strobe in those cycles; CPU strobes pass through; word 5 rewritten after SETUP; done delayed by 3 cycles (2 frozen + re-SETUP).
- abort during SETUP of word 3 → word 3 written, then IDLE; done never pulses; next start begins at word 0.
- start pulsed while busy → ignored; a single done pulse at the expected cycle.
- _reset low during word 7 → next cycle busy=0, dat_we_l=dat_we_h=0, dat_* track cpu_*; no done.
